pipeline_sequencer: RTL and testbench

Central control sequencer for the 8-bit, 5-stage pipelined datapath (IF/ID/EX/MEM/WB, 16-bit instructions, 8-register file, 8-bit PC). It decodes the instruction held in ID into datapath control and carries the control bits through EX, MEM and WB alongside the data. It also resolves jumps and taken branches in EX and runs the run/drain/halt state machine. It keeps an architectural retired-instruction count.

---
 rtl/pipeline_sequencer.sv | 235 +++++++++++++++++++++++
 tb/tb_pipeline_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// Central control sequencer for the 8-bit 5-stage pipeline: ID decode, EX/MEM/WB control
// pipeline, EX-stage jump/branch resolution, run/drain/halt sequencing and retire counting.
module pipeline_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] instr_ID,
  input  logic        stall,
  input  logic        flush_in,
  input  logic        branch_taken_EX,
  output logic [1:0]  ImmSrc,
  output logic        ALUsrc,
  output logic [3:0]  opcode,
  output logic        dir,
  output logic        MemRead_MEM,
  output logic        MemWrite_MEM,
  output logic        RegWrite_MEM,
  output logic        ResultSrc_MEM,
  output logic        RegWrite_WB,
  output logic        jump,
  output logic        PC_sel,
  output logic [7:0]  branch_target,
  output logic        flush,
  output logic        running,
  output logic        halted,
  output logic [15:0] retired
);

  localparam logic [3:0] OpAdd   = 4'h1;
  localparam logic [3:0] OpSub   = 4'h2;
  localparam logic [3:0] OpAnd   = 4'h3;
  localparam logic [3:0] OpOr    = 4'h4;
  localparam logic [3:0] OpXor   = 4'h5;
  localparam logic [3:0] OpShift = 4'h6;
  localparam logic [3:0] OpAddi  = 4'h7;
  localparam logic [3:0] OpLoad  = 4'h8;
  localparam logic [3:0] OpStore = 4'h9;
  localparam logic [3:0] OpBeq   = 4'hA;
  localparam logic [3:0] OpBne   = 4'hB;
  localparam logic [3:0] OpJmp   = 4'hC;
  localparam logic [3:0] OpHalt  = 4'hF;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StHalted} state_e;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       resultsrc;
    logic       is_branch;
    logic       is_jump;
    logic [7:0] target;
  } ex_t;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic resultsrc;
  } mem_t;

  typedef struct packed {
    logic valid;
    logic regwrite;
  } wb_t;

  state_e      state_q, state_d;
  logic [1:0]  drain_cnt_q, drain_cnt_d;
  ex_t         ex_q, ex_d;
  mem_t        mem_q, mem_d;
  wb_t         wb_q, wb_d;
  logic [15:0] retired_q, retired_d;

  logic [1:0] dec_immsrc;
  logic       dec_alusrc;
  logic [3:0] dec_opcode;
  logic       dec_dir;
  logic       dec_regwrite;
  logic       dec_memread;
  logic       dec_memwrite;
  logic       dec_resultsrc;
  logic       dec_is_branch;
  logic       dec_is_jump;
  logic       dec_is_halt;

  logic run;
  logic redirect;
  logic id_blocked;
  logic issue;
  logic halt_take;

  // Register fields are decoded by the datapath, not here.
  logic unused_fields;
  assign unused_fields = ^instr_ID[11:8];

  always_comb begin
    dec_immsrc    = 2'b00;
    dec_alusrc    = 1'b0;
    dec_opcode    = instr_ID[15:12];
    dec_dir       = 1'b0;
    dec_regwrite  = 1'b0;
    dec_memread   = 1'b0;
    dec_memwrite  = 1'b0;
    dec_resultsrc = 1'b0;
    dec_is_branch = 1'b0;
    dec_is_jump   = 1'b0;
    dec_is_halt   = 1'b0;
    case (instr_ID[15:12])
      OpAdd, OpSub, OpAnd, OpOr, OpXor: dec_regwrite = 1'b1;
      OpShift: begin
        dec_regwrite = 1'b1;
        dec_dir      = instr_ID[0];
      end
      OpAddi: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_immsrc   = 2'b01;
      end
      OpLoad: begin
        dec_regwrite  = 1'b1;
        dec_memread   = 1'b1;
        dec_resultsrc = 1'b1;
        dec_alusrc    = 1'b1;
        dec_immsrc    = 2'b01;
      end
      OpStore: begin
        dec_memwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_immsrc   = 2'b10;
      end
      OpBeq, OpBne: begin
        dec_is_branch = 1'b1;
        dec_immsrc    = 2'b11;
      end
      OpJmp: begin
        dec_is_jump = 1'b1;
        dec_immsrc  = 2'b11;
      end
      OpHalt: dec_is_halt = 1'b1;
      // NOP and the reserved opcodes present as NOP.
      default: dec_opcode = 4'h0;
    endcase
  end

  assign run        = (state_q == StRun);
  assign jump       = ex_q.valid & ex_q.is_jump;
  assign PC_sel     = ex_q.valid & ex_q.is_branch & branch_taken_EX;
  assign redirect   = jump | PC_sel;
  assign id_blocked = stall | flush_in | redirect;
  assign issue      = run & ~id_blocked & ~dec_is_halt;
  assign halt_take  = run & ~id_blocked & dec_is_halt;

  always_comb begin
    ex_d = '0;
    if (issue) begin
      ex_d.valid     = 1'b1;
      ex_d.regwrite  = dec_regwrite;
      ex_d.memread   = dec_memread;
      ex_d.memwrite  = dec_memwrite;
      ex_d.resultsrc = dec_resultsrc;
      ex_d.is_branch = dec_is_branch;
      ex_d.is_jump   = dec_is_jump;
      ex_d.target    = instr_ID[7:0];
    end
    mem_d.valid     = ex_q.valid;
    mem_d.regwrite  = ex_q.regwrite;
    mem_d.memread   = ex_q.memread;
    mem_d.memwrite  = ex_q.memwrite;
    mem_d.resultsrc = ex_q.resultsrc;
    wb_d.valid      = mem_q.valid;
    wb_d.regwrite   = mem_q.regwrite;
    retired_d       = retired_q;
    if (wb_q.valid && (retired_q != 16'hFFFF)) begin
      retired_d = retired_q + 16'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StRun;
      end
      StRun: begin
        if (halt_take) begin
          state_d     = StDrain;
          drain_cnt_d = 2'd3;
        end
      end
      StDrain: begin
        if (drain_cnt_q == 2'd0) state_d = StHalted;
        else drain_cnt_d = drain_cnt_q - 2'd1;
      end
      StHalted: state_d = StHalted;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      drain_cnt_q <= 2'd0;
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      retired_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      retired_q   <= retired_d;
    end
  end

  assign ImmSrc        = run ? dec_immsrc : 2'b00;
  assign ALUsrc        = run & dec_alusrc;
  assign opcode        = run ? dec_opcode : 4'h0;
  assign dir           = run & dec_dir;
  assign MemRead_MEM   = mem_q.memread;
  assign MemWrite_MEM  = mem_q.memwrite;
  assign RegWrite_MEM  = mem_q.regwrite;
  assign ResultSrc_MEM = mem_q.resultsrc;
  assign RegWrite_WB   = wb_q.regwrite;
  assign branch_target = ex_q.target;
  assign flush         = redirect | ~run;
  assign running       = run;
  assign halted        = (state_q == StHalted);
  assign retired       = retired_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Randomized and directed bench for pipeline_sequencer against an in-flight-queue reference
// model of the issue/retire behaviour.
module tb_pipeline_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] instr_ID;
  logic        stall;
  logic        flush_in;
  logic        branch_taken_EX;
  logic [1:0]  ImmSrc;
  logic        ALUsrc;
  logic [3:0]  opcode;
  logic        dir;
  logic        MemRead_MEM, MemWrite_MEM, RegWrite_MEM, ResultSrc_MEM;
  logic        RegWrite_WB;
  logic        jump, PC_sel;
  logic [7:0]  branch_target;
  logic        flush, running, halted;
  logic [15:0] retired;

  pipeline_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .instr_ID        (instr_ID),
    .stall           (stall),
    .flush_in        (flush_in),
    .branch_taken_EX (branch_taken_EX),
    .ImmSrc          (ImmSrc),
    .ALUsrc          (ALUsrc),
    .opcode          (opcode),
    .dir             (dir),
    .MemRead_MEM     (MemRead_MEM),
    .MemWrite_MEM    (MemWrite_MEM),
    .RegWrite_MEM    (RegWrite_MEM),
    .ResultSrc_MEM   (ResultSrc_MEM),
    .RegWrite_WB     (RegWrite_WB),
    .jump            (jump),
    .PC_sel          (PC_sel),
    .branch_target   (branch_target),
    .flush           (flush),
    .running         (running),
    .halted          (halted),
    .retired         (retired)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One in-flight instruction (or bubble) as it travels EX -> MEM -> WB.
  typedef struct {
    bit       valid;
    bit       rw, mr, mw, rs, br, jp;
    bit [7:0] tgt;
  } slot_t;

  typedef enum int {MIdle, MRun, MDrain, MHalted} mstate_t;

  slot_t       pipe[$];  // [0]=EX, [1]=MEM, [2]=WB
  mstate_t     ms;
  int          drain_age;
  int unsigned m_retired;

  function automatic void spec_decode(input logic [15:0] ins, output logic [1:0] imm,
                                      output bit alu, output logic [3:0] opc, output bit d,
                                      output slot_t s, output bit is_halt);
    imm = 2'b00; alu = 0; d = 0; is_halt = 0;
    opc = ins[15:12];
    s = '{default: 0};
    s.tgt = ins[7:0];
    case (ins[15:12])
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: s.rw = 1;
      4'h6: begin s.rw = 1; d = ins[0]; end
      4'h7: begin s.rw = 1; alu = 1; imm = 2'b01; end
      4'h8: begin s.rw = 1; s.mr = 1; s.rs = 1; alu = 1; imm = 2'b01; end
      4'h9: begin s.mw = 1; alu = 1; imm = 2'b10; end
      4'hA, 4'hB: begin s.br = 1; imm = 2'b11; end
      4'hC: begin s.jp = 1; imm = 2'b11; end
      4'hF: is_halt = 1;
      default: opc = 4'h0;
    endcase
  endfunction

  task automatic model_reset();
    slot_t b;
    b = '{default: 0};
    pipe.delete();
    repeat (3) pipe.push_back(b);
    ms = MIdle;
    drain_age = 0;
    m_retired = 0;
  endtask

  // Entered and left at a negedge: drive, check before the edge, clock, advance the model.
  task automatic step(input logic [15:0] ins, input bit st, input bit fl, input bit bt,
                      input bit go);
    logic [1:0] imm;
    logic [3:0] opc;
    bit alu, d, is_halt, run, e_jump, e_pcsel;
    slot_t s, nx;
    instr_ID = ins; stall = st; flush_in = fl; branch_taken_EX = bt; start = go;
    #1;
    spec_decode(ins, imm, alu, opc, d, s, is_halt);
    run = (ms == MRun);
    e_jump  = pipe[0].valid && pipe[0].jp;
    e_pcsel = pipe[0].valid && pipe[0].br && bt;
    check("ImmSrc", ImmSrc, run ? imm : 2'b00);
    check("ALUsrc", ALUsrc, run && alu);
    check("opcode", opcode, run ? opc : 4'h0);
    check("dir", dir, run && d);
    check("MemRead_MEM", MemRead_MEM, pipe[1].mr);
    check("MemWrite_MEM", MemWrite_MEM, pipe[1].mw);
    check("RegWrite_MEM", RegWrite_MEM, pipe[1].rw);
    check("ResultSrc_MEM", ResultSrc_MEM, pipe[1].rs);
    check("RegWrite_WB", RegWrite_WB, pipe[2].rw);
    check("jump", jump, e_jump);
    check("PC_sel", PC_sel, e_pcsel);
    if (e_jump || e_pcsel) check("branch_target", branch_target, pipe[0].tgt);
    check("flush", flush, e_jump || e_pcsel || !run);
    check("running", running, run);
    check("halted", halted, ms == MHalted);
    check("retired", retired, m_retired);
    @(posedge clk);
    nx = '{default: 0};
    if (run && !st && !fl && !e_jump && !e_pcsel && !is_halt) begin
      nx = s;
      nx.valid = 1;
    end
    if (pipe[2].valid && m_retired < 32'hFFFF) m_retired++;
    pipe.push_front(nx);
    void'(pipe.pop_back());
    case (ms)
      MIdle: if (go) ms = MRun;
      MRun: if (is_halt && !st && !fl && !e_jump && !e_pcsel) begin
        ms = MDrain;
        drain_age = 0;
      end
      MDrain: begin
        drain_age++;
        if (drain_age == 4) ms = MHalted;
      end
      default: ;
    endcase
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_flush", flush, 1'b1);
    check("rst_running", running, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_retired", retired, 16'd0);
    check("rst_RegWrite_WB", RegWrite_WB, 1'b0);
    check("rst_RegWrite_MEM", RegWrite_MEM, 1'b0);
    check("rst_jump", jump, 1'b0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [15:0] rand_instr(input bit allow_halt);
    logic [31:0] r;
    logic [3:0] op;
    r = $urandom();
    op = r[15:12];
    if (op == 4'hF && (!allow_halt || r[31:28] != 4'h0)) op = {1'b0, r[30:28]};
    return {op, r[11:0]};
  endfunction

  localparam logic [15:0] INop  = 16'h0000;
  localparam logic [15:0] IAdd  = 16'h1234;
  localparam logic [15:0] ISub  = 16'h2345;
  localparam logic [15:0] IXor  = 16'h5111;
  localparam logic [15:0] IShl  = 16'h6241;
  localparam logic [15:0] IAddi = 16'h7A05;
  localparam logic [15:0] ILoad = 16'h8C03;
  localparam logic [15:0] IStr  = 16'h9C07;
  localparam logic [15:0] IBeq  = 16'hA05A;
  localparam logic [15:0] IJmp  = 16'hC0C3;
  localparam logic [15:0] IRsv  = 16'hD0FF;
  localparam logic [15:0] IHalt = 16'hF000;

  initial begin
    reset = 1'b0; start = 1'b0; instr_ID = '0; stall = 1'b0; flush_in = 1'b0;
    branch_taken_EX = 1'b0;
    @(negedge clk);
    do_reset();
    step(IAdd, 0, 0, 0, 0);   // idle: ID outputs gated
    step(INop, 0, 0, 0, 1);   // start
    step(IAddi, 0, 0, 0, 0);
    repeat (4) step(INop, 0, 0, 0, 0);
    step(ILoad, 0, 0, 0, 0);
    step(IAdd, 1, 0, 0, 0);
    step(IAdd, 0, 0, 0, 0);
    step(IShl, 0, 0, 0, 0);
    step(IStr, 0, 0, 0, 0);
    step(IRsv, 0, 0, 0, 0);
    repeat (4) step(INop, 0, 0, 0, 0);
    step(IBeq, 0, 0, 0, 0);
    step(IAdd, 0, 0, 1, 0);   // taken: this ID instruction is squashed
    step(IAdd, 0, 0, 1, 0);
    step(IBeq, 0, 0, 0, 0);
    step(IAdd, 0, 0, 0, 0);   // not taken
    step(IJmp, 0, 0, 0, 0);
    step(IHalt, 0, 0, 0, 0);  // HALT on the wrong path of a jump
    repeat (4) step(INop, 0, 0, 0, 0);

    do_reset();
    step(INop, 0, 0, 0, 1);
    step(IAdd, 0, 0, 0, 0);
    step(ISub, 0, 0, 0, 0);
    step(IXor, 0, 0, 0, 0);
    step(IHalt, 0, 0, 0, 0);
    repeat (6) step(IAdd, 0, 0, 0, 1);   // start in DRAIN/HALTED is ignored

    do_reset();
    step(INop, 0, 0, 0, 1);
    step(IAdd, 0, 0, 0, 0);
    step(IHalt, 0, 1, 0, 0);  // squashed by flush_in
    step(IHalt, 1, 0, 0, 0);  // held by stall
    step(IAdd, 0, 0, 0, 0);
    step(IHalt, 1, 0, 0, 0);
    step(IHalt, 0, 0, 0, 0);  // accepted once stall clears
    repeat (6) step(INop, 0, 0, 0, 0);

    do_reset();
    step(INop, 0, 0, 0, 1);
    for (int i = 0; i < 1500; i++) begin
      if (ms == MHalted || $urandom_range(0, 199) == 0) begin
        do_reset();
        step(INop, 0, 0, 0, 1);
      end else begin
        step(rand_instr(1'b1), $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
      end
    end

    do_reset();
    step(INop, 0, 0, 0, 1);
    for (int i = 0; i < 65545; i++) step(IAdd, 0, 0, 0, 0);
    check("retired_saturated", retired, 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
